mm_host: RTL

Host-side driver for the matrix-multiplier stream interface. It holds two signed 8-bit operand matrices, each up to 4x4, written by a local register port. On `start` it transmits A and then B on the `in_data`/`col_end`/`row_end` stream. It then collects the 20-bit product stream using `valid`/`change_row` into a 4x4 result buffer, or reports an illegal (dimension-mismatch) job. It sits between the system controller and the multiplier core as the other end of the multiplier's load/output protocol.

---
 rtl/mm_pkg.sv | 19 +
 rtl/mm_rc_walker.sv | 36 +++
 rtl/mm_host.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/mm_pkg.sv
// mm_pkg: shared constants, FSM state type and element-index helper for the
// matrix-multiplier host driver.
package mm_pkg;
  localparam int DATA_W  = 8;
  localparam int RES_W   = 20;
  localparam int DIM_W   = 2;
  localparam int MAX_DIM = 4;
  localparam int NELEM   = MAX_DIM * MAX_DIM;

  typedef enum logic [2:0] {
    IDLE, SEND_A, SEND_B, WAIT, COLLECT, DONE
  } mm_host_state_t;

  // Row-major element index r*4+c; with 2-bit r/c this is exactly {r, c}.
  function automatic logic [3:0] idx(input logic [DIM_W-1:0] r,
                                     input logic [DIM_W-1:0] c);
    return {r, c};
  endfunction
endpackage

// File: rtl/mm_rc_walker.sv
// mm_rc_walker: row-major row/col counter shared by the send and collect
// phases. Wraps to (0,0) after the last element so SEND_A hands a clean
// walker to SEND_B, and SEND_B hands one to WAIT/COLLECT.
module mm_rc_walker import mm_pkg::*; (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             step,
  input  logic [DIM_W-1:0] r_lim,
  input  logic [DIM_W-1:0] c_lim,
  output logic [DIM_W-1:0] r,
  output logic [DIM_W-1:0] c,
  output logic             col_last,
  output logic             mat_last
);
  assign col_last = (c == c_lim);
  assign mat_last = col_last && (r == r_lim);

  // Advance one element per step; clear has priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r <= '0;
      c <= '0;
    end else if (clear) begin
      r <= '0;
      c <= '0;
    end else if (step) begin
      if (col_last) begin
        c <= '0;
        r <= mat_last ? '0 : r + 1'b1;
      end else begin
        c <= c + 1'b1;
      end
    end
  end
endmodule

// File: rtl/mm_host.sv
// mm_host: host-side driver for the matrix-multiplier stream interface.
// Streams A then B from local operand buffers, then captures the product
// stream into a 4x4 result buffer. Optional macro MM_HOST_CHECK_EN adds a
// sticky proto_err output that flags inconsistent change_row / is_legal.
module mm_host import mm_pkg::*; #(
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [3:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DIM_W-1:0]  a_rows,
  input  logic [DIM_W-1:0]  a_cols,
  input  logic [DIM_W-1:0]  b_rows,
  input  logic [DIM_W-1:0]  b_cols,
  input  logic              start,
  output logic              done,
  output logic              legal,
  output logic              timeout,
  input  logic [3:0]        res_rd_addr,
  output logic [RES_W-1:0]  res_rd_data,
  output logic [DATA_W-1:0] mm_in_data,
  output logic              mm_col_end,
  output logic              mm_row_end,
  input  logic              mm_busy,
  input  logic              mm_valid,
  input  logic              mm_change_row,
  input  logic              mm_is_legal,
  input  logic [RES_W-1:0]  mm_out_data
`ifdef MM_HOST_CHECK_EN
  ,
  output logic              proto_err
`endif
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  mm_host_state_t    state;
  logic [DIM_W-1:0]  ar, ac, br, bc;
  logic [CNT_W-1:0]  tmo_cnt;
  logic [DATA_W-1:0] mem_a [NELEM];
  logic [DATA_W-1:0] mem_b [NELEM];
  logic [RES_W-1:0]  res   [NELEM];

  logic [DIM_W-1:0]  w_r, w_c, lim_r, lim_c;
  logic              w_col_last, w_mat_last, w_step;
  logic              go, cap, job_legal;

  // Next stream element: what the stream register loads at this edge.
  logic              snd_nxt, nxt_b;
  logic [DIM_W-1:0]  nr, nc, nlr, nlc;

  assign go          = (state == IDLE) && start && !mm_busy;
  assign job_legal   = (ac == br);
  assign cap         = mm_valid && ((state == COLLECT) || (state == WAIT && job_legal));
  assign w_step      = (state == SEND_A) || (state == SEND_B) || cap;
  assign res_rd_data = res[res_rd_addr];

  // Walker limits follow the phase; WAIT/COLLECT walk the ar x bc result.
  always_comb begin
    lim_r = ar;
    lim_c = bc;
    case (state)
      SEND_A:  begin lim_r = ar; lim_c = ac; end
      SEND_B:  begin lim_r = br; lim_c = bc; end
      default: ;
    endcase
  end

  mm_rc_walker u_walker (
    .clk      (clk),
    .rst      (rst),
    .clear    (go),
    .step     (w_step),
    .r_lim    (lim_r),
    .c_lim    (lim_c),
    .r        (w_r),
    .c        (w_c),
    .col_last (w_col_last),
    .mat_last (w_mat_last)
  );

  // Pick the element that follows the one currently on the stream.
  always_comb begin
    snd_nxt = 1'b0;
    nxt_b   = 1'b0;
    nr      = '0;
    nc      = '0;
    nlr     = '0;
    nlc     = '0;
    case (state)
      IDLE: if (go) begin
        snd_nxt = 1'b1;
        nlr     = a_rows;
        nlc     = a_cols;
      end
      SEND_A: begin
        snd_nxt = 1'b1;
        if (w_mat_last) begin
          nxt_b = 1'b1;
          nlr   = br;
          nlc   = bc;
        end else begin
          nr  = w_col_last ? w_r + 1'b1 : w_r;
          nc  = w_col_last ? '0 : w_c + 1'b1;
          nlr = ar;
          nlc = ac;
        end
      end
      SEND_B: if (!w_mat_last) begin
        snd_nxt = 1'b1;
        nxt_b   = 1'b1;
        nr      = w_col_last ? w_r + 1'b1 : w_r;
        nc      = w_col_last ? '0 : w_c + 1'b1;
        nlr     = br;
        nlc     = bc;
      end
      default: ;
    endcase
  end

  // Job FSM, operand/result buffers and registered stream outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ar         <= '0;
      ac         <= '0;
      br         <= '0;
      bc         <= '0;
      tmo_cnt    <= '0;
      done       <= 1'b0;
      legal      <= 1'b0;
      timeout    <= 1'b0;
      mm_in_data <= '0;
      mm_col_end <= 1'b0;
      mm_row_end <= 1'b0;
      for (int i = 0; i < NELEM; i++) begin
        mem_a[i] <= '0;
        mem_b[i] <= '0;
        res[i]   <= '0;
      end
`ifdef MM_HOST_CHECK_EN
      proto_err  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;

      if (snd_nxt) begin
        mm_in_data <= nxt_b ? mem_b[idx(nr, nc)] : mem_a[idx(nr, nc)];
        mm_col_end <= (nc == nlc);
        mm_row_end <= (nc == nlc) && (nr == nlr);
      end else begin
        mm_in_data <= '0;
        mm_col_end <= 1'b0;
        mm_row_end <= 1'b0;
      end

      if (state == IDLE && wr_en) begin
        if (wr_sel) mem_b[wr_addr] <= wr_data;
        else        mem_a[wr_addr] <= wr_data;
      end

      case (state)
        IDLE: if (go) begin
          ar      <= a_rows;
          ac      <= a_cols;
          br      <= b_rows;
          bc      <= b_cols;
          legal   <= 1'b0;
          timeout <= 1'b0;
`ifdef MM_HOST_CHECK_EN
          proto_err <= 1'b0;
`endif
          state   <= SEND_A;
        end
        SEND_A: if (w_mat_last) state <= SEND_B;
        SEND_B: if (w_mat_last) begin
          tmo_cnt <= '0;
          state   <= WAIT;
        end
        WAIT, COLLECT: begin
          if (mm_valid) begin
            tmo_cnt <= '0;
            if (!cap) begin
              // Illegal job: the single marker ends it, data discarded.
              legal <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              res[idx(w_r, w_c)] <= mm_out_data;
`ifdef MM_HOST_CHECK_EN
              if (mm_change_row != w_col_last)  proto_err <= 1'b1;
              if (!mm_is_legal && !w_mat_last)  proto_err <= 1'b1;
`endif
              if (w_mat_last) begin
                legal <= 1'b1;
                done  <= 1'b1;
                state <= DONE;
              end else begin
                state <= COLLECT;
              end
            end
          end else if (tmo_cnt == TMO_LAST) begin
            timeout <= 1'b1;
            legal   <= job_legal;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifndef MM_HOST_CHECK_EN
  logic unused_chk;
  assign unused_chk = &{1'b0, mm_change_row, mm_is_legal};
`endif
endmodule
